rsa_modexp_ctrl: RTL and testbench

Sequencer for RSA decryption m = c^d mod n. It drives `secondaryInputTop`, the Montgomery precompute that produces n0p, r and t from n, then schedules a shared Montgomery multiplier through a left-to-right square-and-multiply exponentiation. It caches the precomputed constants and skips the precompute when n is unchanged. It sits between the top-level request interface and both arithmetic engines.

---
 rtl/rsa_pkg.sv | 21 ++
 rtl/rsa_exp_scan.sv | 38 +++
 rtl/rsa_modexp_ctrl.sv | 172 +++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation sequencer.
// Pure declarations: no logic, no latency, no flow control.
package rsa_pkg;

    localparam int WIDTH_DEF = 1024;
    localparam int WORD_DEF  = 32;
    localparam int MONT_ONE  = 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_PRE_WAIT,
        S_TO_MONT,
        S_SKIP,
        S_SQR,
        S_MUL,
        S_FROM_MONT,
        S_FINISH
    } state_t;

endpackage

// File: rtl/rsa_exp_scan.sv
// Exponent register and MSB-first bit-index walker for square-and-multiply.
// Load and decrement take effect on the next edge; no flow control.
module rsa_exp_scan
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d_in,
    input  logic             dec,
    output logic             exp_bit,
    output logic             is_zero,
    output logic             idx_zero
);

    logic [WIDTH-1:0] d_q;
    logic [IDXW-1:0]  idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= '0;
            idx <= '0;
        end else if (load) begin
            d_q <= d_in;
            idx <= IDXW'(WIDTH - 1);
        end else if (dec && idx != '0) begin
            idx <= idx - 1'b1;
        end
    end

    assign exp_bit  = d_q[idx];
    assign is_zero  = (d_q == '0);
    assign idx_zero = (idx == '0);

endmodule

// File: rtl/rsa_modexp_ctrl.sv
// Sequences precompute (cached per modulus) and Montgomery multiplies for m = c^d mod n.
// busy from the cycle after start until done; every multiply waits for mm_done, start ignored while busy.
module rsa_modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int WORD  = WORD_DEF,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] m,
    output logic             pre_start,
    output logic [WIDTH-1:0] pre_n,
    input  logic             pre_done,
    input  logic [WORD-1:0]  pre_n0p,
    input  logic [WIDTH-1:0] pre_r,
    input  logic [WIDTH-1:0] pre_t,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    output logic [WORD-1:0]  mm_n0p,
    input  logic             mm_done,
    input  logic [WIDTH-1:0] mm_result
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] n_q, c_q, acc, cbar, r_q, t_q, cache_n;
    logic [WORD-1:0]  n0p_q;
    logic             cache_valid, issued, mm_ack;
    logic             load, dec, exp_bit, is_zero, idx_zero;

    rsa_exp_scan #(.WIDTH(WIDTH), .IDXW(IDXW)) u_scan (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .d_in     (d),
        .dec      (dec),
        .exp_bit  (exp_bit),
        .is_zero  (is_zero),
        .idx_zero (idx_zero)
    );

    // A completion only counts against a multiply this controller actually issued.
    assign mm_ack = issued && mm_done;

    assign pre_n  = n_q;
    assign mm_n   = n_q;
    assign mm_n0p = n0p_q;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        dec       = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        pre_start = 1'b0;
        mm_start  = 1'b0;
        mm_a      = '0;
        mm_b      = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (cache_valid && cache_n == n) ? S_TO_MONT : S_PRE;
                end
            end
            S_PRE: begin
                pre_start = 1'b1;
                state_nxt = S_PRE_WAIT;
            end
            S_PRE_WAIT: if (pre_done) state_nxt = S_TO_MONT;
            S_TO_MONT: begin
                mm_start = !issued;
                mm_a     = c_q;
                mm_b     = t_q;
                if (mm_ack) state_nxt = is_zero ? S_FROM_MONT : S_SKIP;
            end
            S_SKIP: begin
                if (exp_bit) state_nxt = S_SQR;
                else         dec       = 1'b1;
            end
            S_SQR: begin
                mm_start = !issued;
                mm_a     = acc;
                mm_b     = acc;
                if (mm_ack) begin
                    if (exp_bit)       state_nxt = S_MUL;
                    else if (idx_zero) state_nxt = S_FROM_MONT;
                    else               dec       = 1'b1;
                end
            end
            S_MUL: begin
                mm_start = !issued;
                mm_a     = acc;
                mm_b     = cbar;
                if (mm_ack) begin
                    if (idx_zero) begin
                        state_nxt = S_FROM_MONT;
                    end else begin
                        dec       = 1'b1;
                        state_nxt = S_SQR;
                    end
                end
            end
            S_FROM_MONT: begin
                mm_start = !issued;
                mm_a     = acc;
                mm_b     = WIDTH'(MONT_ONE);
                if (mm_ack) state_nxt = S_FINISH;
            end
            S_FINISH: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            issued      <= 1'b0;
            cache_valid <= 1'b0;
            cache_n     <= '0;
            n_q         <= '0;
            c_q         <= '0;
            acc         <= '0;
            cbar        <= '0;
            n0p_q       <= '0;
            r_q         <= '0;
            t_q         <= '0;
            m           <= '0;
        end else begin
            state <= state_nxt;
            if (mm_start)    issued <= 1'b1;
            else if (mm_ack) issued <= 1'b0;
            if (load) begin
                n_q <= n;
                c_q <= c;
            end
            if (state == S_PRE_WAIT && pre_done) begin
                n0p_q       <= pre_n0p;
                r_q         <= pre_r;
                t_q         <= pre_t;
                cache_n     <= n_q;
                cache_valid <= 1'b1;
            end
            if (mm_ack) begin
                case (state)
                    S_TO_MONT: begin
                        cbar <= mm_result;
                        acc  <= r_q;
                    end
                    S_SQR, S_MUL: acc <= mm_result;
                    S_FROM_MONT:  m   <= mm_result;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl at WIDTH=32 with behavioural precompute and Montgomery multiplier.
module tb_rsa_modexp_ctrl;

    localparam int W  = 32;
    localparam int WD = 32;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [W-1:0]  n, d, c, m, pre_n, pre_r, pre_t, mm_a, mm_b, mm_n, mm_result;
    logic [WD-1:0] pre_n0p, mm_n0p;
    logic          busy, done, pre_start, pre_done, mm_start, mm_done;

    rsa_modexp_ctrl #(.WIDTH(W), .WORD(WD)) dut (
        .clk(clk), .reset(reset), .start(start), .n(n), .d(d), .c(c),
        .busy(busy), .done(done), .m(m),
        .pre_start(pre_start), .pre_n(pre_n), .pre_done(pre_done),
        .pre_n0p(pre_n0p), .pre_r(pre_r), .pre_t(pre_t),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_n(mm_n), .mm_n0p(mm_n0p),
        .mm_done(mm_done), .mm_result(mm_result)
    );

    always #5 clk = ~clk;

    int checks = 0, passed = 0;
    int pre_cnt = 0, mm_cnt = 0, done_cnt = 0, op_err = 0;
    bit rand_lat = 1'b0, op_check_en = 1'b1;
    int fix_lat = 1;
    logic [W-1:0] cur_n = '0;
    bit           mc_valid = 1'b0;
    logic [W-1:0] mc_n = '0;

    // ---------------- reference arithmetic ----------------
    function automatic logic [W-1:0] modpow(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] nn);
        longint unsigned r = 1, x = 64'(b) % 64'(nn);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % 64'(nn);
            x = (x * x) % 64'(nn);
        end
        return W'(r % 64'(nn));
    endfunction

    function automatic int mult_ops(input logic [W-1:0] dd);
        int bl = 0;
        for (int i = 0; i < W; i++) if (dd[i]) bl = i + 1;
        return 2 + bl + $countones(dd);
    endfunction

    function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] nn);
        logic [95:0] x = 96'(a) * 96'(b);
        for (int i = 0; i < W; i++) begin
            if (x[0]) x = x + 96'(nn);
            x = x >> 1;
        end
        return W'(x % 96'(nn));
    endfunction

    function automatic logic [WD-1:0] n0p_of(input logic [W-1:0] nn);
        logic [WD-1:0] inv = nn;
        repeat (5) inv = inv * (32'd2 - nn * inv);
        return -inv;
    endfunction

    function automatic logic [W-1:0] r_of(input logic [W-1:0] nn);
        return W'((64'd1 << W) % 64'(nn));
    endfunction

    function automatic logic [W-1:0] t_of(input logic [W-1:0] nn);
        return W'((64'(r_of(nn)) * 64'(r_of(nn))) % 64'(nn));
    endfunction

    // ---------------- behavioural engines and pulse monitor ----------------
    logic [W-1:0] pre_cap;
    int           pre_wait;
    initial begin
        pre_done = 1'b0; pre_n0p = '0; pre_r = '0; pre_t = '0;
        forever begin
            @(negedge clk);
            pre_done = 1'b0;
            if (pre_start === 1'b1) begin
                pre_cap = pre_n;
                if (op_check_en && pre_cap !== cur_n) op_err++;
                pre_wait = $urandom_range(1, 5);
                repeat (pre_wait) @(negedge clk);
                pre_n0p  = n0p_of(pre_cap);
                pre_r    = r_of(pre_cap);
                pre_t    = t_of(pre_cap);
                pre_done = 1'b1;
            end
        end
    end

    logic [W-1:0] op_a, op_b;
    int           mm_wait;
    initial begin
        mm_done = 1'b0; mm_result = '0;
        forever begin
            @(negedge clk);
            mm_done = 1'b0;
            if (mm_start === 1'b1) begin
                op_a = mm_a;
                op_b = mm_b;
                if (op_check_en && (mm_n !== cur_n || mm_n0p !== n0p_of(cur_n))) op_err++;
                mm_wait = rand_lat ? $urandom_range(1, 20) : fix_lat;
                repeat (mm_wait) begin
                    @(negedge clk);
                    if (op_check_en && (mm_a !== op_a || mm_b !== op_b)) op_err++;
                end
                mm_result = mont(op_a, op_b, cur_n);
                mm_done   = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (pre_start === 1'b1) pre_cnt++;
            if (mm_start === 1'b1)  mm_cnt++;
            if (done === 1'b1)      done_cnt++;
        end
    end

    // ---------------- request driver with inline checks ----------------
    task automatic run_req(input logic [W-1:0] nn, input logic [W-1:0] dd,
                           input logic [W-1:0] cc, input bit hammer, input string tag);
        bit           exp_hit = mc_valid && (mc_n == nn);
        logic [W-1:0] exp_m   = modpow(cc, dd, nn);
        int           exp_ops = mult_ops(dd);
        bit           got = 1'b0;
        cur_n = nn; pre_cnt = 0; mm_cnt = 0; done_cnt = 0;
        n = nn; d = dd; c = cc; start = 1'b1;
        @(negedge clk);
        start = hammer;
        checks++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        else passed++;
        checks++;
        if ((exp_hit ? mm_start : pre_start) !== 1'b1)
            $display("FAIL %s first_pulse: pre_start=%b mm_start=%b hit=%0b", tag, pre_start, mm_start, exp_hit);
        else passed++;
        for (int i = 0; i < 4000 && !got; i++) begin
            if (done === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                if (hammer) begin n = $urandom; d = $urandom; c = $urandom; end
            end
        end
        start = 1'b0;
        checks++;
        if (!got) $display("FAIL %s done_timeout: got none want done", tag);
        else if (m !== exp_m) $display("FAIL %s result: got %0d want %0d", tag, m, exp_m);
        else passed++;
        mc_valid = 1'b1; mc_n = nn;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt !== 1)
            $display("FAIL %s idle_after: busy=%b done_cnt=%0d want 0/1", tag, busy, done_cnt);
        else passed++;
        checks++;
        if (pre_cnt !== (exp_hit ? 0 : 1))
            $display("FAIL %s pre_starts: got %0d want %0d", tag, pre_cnt, exp_hit ? 0 : 1);
        else passed++;
        checks++;
        if (mm_cnt !== exp_ops) $display("FAIL %s mm_starts: got %0d want %0d", tag, mm_cnt, exp_ops);
        else passed++;
    endtask

    task automatic test_reset();
        logic [W-1:0] outs [0:2];
        reset = 1'b1; start = 1'b0; n = '0; d = '0; c = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mc_valid = 1'b0;
        checks++;
        if ({busy, done, pre_start, mm_start} !== 4'b0000)
            $display("FAIL reset_ctrl: busy/done/pre/mm=%b want 0000", {busy, done, pre_start, mm_start});
        else passed++;
        outs[0] = m; outs[1] = mm_a; outs[2] = mm_b;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (outs[i] !== '0) $display("FAIL reset_data%0d: got %0h want 0", i, outs[i]);
            else passed++;
        end
    endtask

    task automatic test_rsa_vector();
        run_req(32'd3233, 32'd2753, 32'd2790, 1'b0, "rsa_vector");
    endtask

    task automatic test_cache_hit();
        run_req(32'd3233, 32'd17, 32'd65, 1'b0, "cache_hit");
    endtask

    task automatic test_zero_exp();
        run_req(32'd3233, 32'd0, 32'd2790, 1'b0, "zero_exp");
    endtask

    task automatic test_reset_mid_sqr();
        bool_wait: begin end
        fix_lat = 10; cur_n = 32'd3233; done_cnt = 0; mm_cnt = 0;
        n = 32'd3233; d = 32'd2753; c = 32'd2790; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && mm_cnt < 4; i++) @(negedge clk);
        checks++;
        if (mm_cnt < 4) $display("FAIL mid_reset_reach_sqr: mm_starts=%0d want 4", mm_cnt);
        else passed++;
        repeat (3) @(negedge clk);
        op_check_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mc_valid = 1'b0;
        checks++;
        if ({busy, done, mm_start, pre_start} !== 4'b0000 || m !== '0 || mm_a !== '0 || mm_b !== '0)
            $display("FAIL mid_reset_outputs: busy/done/mm/pre=%b m=%0h a=%0h b=%0h want all 0",
                     {busy, done, mm_start, pre_start}, m, mm_a, mm_b);
        else passed++;
        repeat (25) @(negedge clk);
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0)
            $display("FAIL mid_reset_late_done: done_cnt=%0d busy=%b want 0/0", done_cnt, busy);
        else passed++;
        op_check_en = 1'b1; fix_lat = 1;
    endtask

    task automatic test_start_while_busy();
        run_req(32'd3233, 32'd2753, 32'd2790, 1'b1, "start_while_busy");
    endtask

    task automatic test_random_latency();
        logic [W-1:0] nn, dd, cc;
        rand_lat = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i != 3) nn = $urandom | 32'h8000_0001;
            dd = $urandom;
            cc = $urandom % nn;
            run_req(nn, dd, cc, 1'b0, $sformatf("random%0d", i));
        end
        rand_lat = 1'b0;
        checks++;
        if (op_err !== 0) $display("FAIL operand_stability: got %0d violations want 0", op_err);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_rsa_vector();
        test_cache_hit();
        test_zero_exp();
        test_reset_mid_sqr();
        test_start_while_busy();
        test_random_latency();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
